combine_2x1_seq: RTL and testbench
==================================

COMBINE_2X1_SEQ -- requirements
Module: combine_2x1_seq

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of one data lane.
REQ-002 The block SHALL have parameter COMMMAND_WIDTH, default 2, giving the width of i_cmd.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 2, giving the entries per input lane FIFO; legal values are powers of two >= 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_valid, input, 2 bits: bit 1 is the high-lane valid and bit 0 is the low-lane valid.
REQ-007 The block SHALL have port i_data_bus, input, 2*DATA_WIDTH bits: high lane is [2*DATA_WIDTH-1:DATA_WIDTH] and low lane is [DATA_WIDTH-1:0].
REQ-008 The block SHALL have port o_ready, output, 2 bits: per-lane ready toward upstream, bit order as i_valid.
REQ-009 The block SHALL have port o_valid, output, 1 bit: output data valid.
REQ-010 The block SHALL have port o_data_bus, output, DATA_WIDTH bits: merged output data.
REQ-011 The block SHALL have port o_src, output, 1 bit: source lane of the current output word (0 = low, 1 = high).
REQ-012 The block SHALL have port i_ready, input, 1 bit: downstream ready.
REQ-013 The block SHALL have port i_en, input, 1 bit: block enable.
REQ-014 The block SHALL have port i_cmd, input, COMMMAND_WIDTH bits: 00 = none, 01 = low lane only, 10 = high lane only, 11 = round-robin merge of both lanes.

Function
REQ-015 Each lane SHALL own a FIFO of FIFO_DEPTH entries with read and write pointers that wrap modulo FIFO_DEPTH and an occupancy counter ranging 0..FIFO_DEPTH.
REQ-016 o_ready[k] SHALL equal i_en AND (occupancy[k] != FIFO_DEPTH), computed from registered state only; there is no same-cycle pop-to-push pass-through when a FIFO is full.
REQ-017 A push to lane k SHALL occur on an edge where i_valid[k] and o_ready[k] are both 1.
REQ-018 The output register SHALL be loadable when i_en = 1 and (o_valid = 0 or i_ready = 1).
REQ-019 Lane selection when the output register is loadable:
  - cmd 00: no lane is selected.
  - cmd 01: lane 0 is selected if non-empty.
  - cmd 10: lane 1 is selected if non-empty.
  - cmd 11, both lanes non-empty: the lane given by the rr pointer is selected, and rr then toggles.
  - cmd 11, one lane non-empty: that lane is selected, and rr is set to the other lane.
REQ-020 On a selection, the FIFO head SHALL pop; o_data_bus SHALL take the head data, o_src SHALL take the lane index, and o_valid SHALL go to 1.
REQ-021 When the output register is loadable and no lane is selected, o_valid SHALL go to 0 and o_data_bus and o_src SHALL hold.
REQ-022 When o_valid = 1 and i_ready = 0, o_valid, o_data_bus and o_src SHALL hold stable (no drop, no overwrite).
REQ-023 Latency: a word pushed at edge E into an empty FIFO, with a free output register and a matching cmd, SHALL appear with o_valid = 1 after edge E+1; sustained throughput SHALL be 1 word per cycle.
REQ-024 A simultaneous push and pop on the same non-full lane SHALL leave the occupancy unchanged and keep data order.
REQ-025 While i_en = 0: no push, no pop, o_ready = 00, and all registers (including rr) SHALL hold.
REQ-026 A change of i_cmd SHALL NOT flush the FIFOs; words in a deselected lane SHALL remain until that lane is selected again.
REQ-027 Per-lane output order SHALL equal that lane's input order.

Reset
REQ-028 On rst = 0 the block SHALL asynchronously clear:
  - all pointers and occupancies, and rr (rr = 0, so the low lane has first priority);
  - o_valid = 0, o_data_bus = {DATA_WIDTH{1'b0}}, o_src = 0.
REQ-029 While rst = 0, o_ready SHALL be 00; after release with i_en = 1, o_ready SHALL be 11.
REQ-030 Reset asserted mid-stream SHALL discard all buffered words; none SHALL appear on the output after release.

Verification
REQ-031 Low-lane test: cmd 01, i_ready = 1, push 0xAAAAAAAA on lane 0 -> after 2 edges o_valid = 1, o_data_bus = 0xAAAAAAAA, o_src = 0.
REQ-032 Merge test: cmd 11, each lane pre-filled with 2 words (A0, A1 low; B0, B1 high), then i_ready = 1 -> output sequence A0, B0, A1, B1 with o_src 0, 1, 0, 1.
REQ-033 Backpressure test: i_ready = 0 with lane 0 pushed 3 times -> the 1st word is held on the output and FIFO_DEPTH more are buffered, then o_ready[0] = 0; raising i_ready -> 3 words drain in order.
REQ-034 Enable test: i_en = 0 for 3 cycles during a merge -> outputs frozen and o_ready = 00; on i_en = 1 the sequence resumes with no loss or duplication.
REQ-035 Deselect test: cmd 10 with lane 0 holding 0xBBBBBBBB -> no output; switch to cmd 01 -> 0xBBBBBBBB emitted with o_src = 0.
REQ-036 Reset test: rst pulled low with both FIFOs non-empty and o_valid = 1 -> o_valid = 0 immediately; after release with no pushes, o_valid stays 0.

Source files
------------

// File: rtl/combine_2x1_seq.sv
// combine_2x1_seq: two-lane to one-lane merger.
// Each input lane has its own small FIFO. A single output register is
// loaded from the lane chosen by i_cmd. Command 11 merges both lanes
// round-robin.
module combine_2x1_seq #(
    parameter int DATA_WIDTH     = 32,
    parameter int COMMMAND_WIDTH = 2,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                i_valid,
    input  logic [2*DATA_WIDTH-1:0]   i_data_bus,
    output logic [1:0]                o_ready,
    output logic                      o_valid,
    output logic [DATA_WIDTH-1:0]     o_data_bus,
    output logic                      o_src,
    input  logic                      i_ready,
    input  logic                      i_en,
    input  logic [COMMMAND_WIDTH-1:0] i_cmd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    localparam logic [COMMMAND_WIDTH-1:0] CMD_LO = COMMMAND_WIDTH'(1);
    localparam logic [COMMMAND_WIDTH-1:0] CMD_HI = COMMMAND_WIDTH'(2);
    localparam logic [COMMMAND_WIDTH-1:0] CMD_RR = COMMMAND_WIDTH'(3);

    logic [DATA_WIDTH-1:0] mem [2][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] lane_data [2];
    logic [AW-1:0]         wr_ptr [2];
    logic [AW-1:0]         rd_ptr [2];
    logic [AW:0]           occ [2];
    logic                  rr;
    logic                  rr_next;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            not_empty;
    logic                  load;
    logic                  sel_valid;
    logic                  sel_lane;

    assign lane_data[0] = i_data_bus[DATA_WIDTH-1:0];
    assign lane_data[1] = i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH];

    // Per-lane ready and push.
    // Ready comes from stored occupancy only, so a full FIFO never accepts a
    // word in the same cycle it pops one.
    always_comb begin
        not_empty = '0;
        o_ready   = '0;
        push      = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            not_empty[k] = (occ[k] != '0);
            o_ready[k]   = rst & i_en & (occ[k] != OCC_FULL);
            push[k]      = i_valid[k] & o_ready[k];
        end
    end

    // Lane selection for the output register, plus the round-robin update.
    always_comb begin
        load      = i_en & (~o_valid | i_ready);
        sel_valid = 1'b0;
        sel_lane  = 1'b0;
        rr_next   = rr;
        if (load) begin
            case (i_cmd)
                CMD_LO: begin
                    sel_valid = not_empty[0];
                    sel_lane  = 1'b0;
                end
                CMD_HI: begin
                    sel_valid = not_empty[1];
                    sel_lane  = 1'b1;
                end
                CMD_RR: begin
                    if (&not_empty) begin
                        sel_valid = 1'b1;
                        sel_lane  = rr;
                        rr_next   = ~rr;
                    end else if (not_empty[0]) begin
                        sel_valid = 1'b1;
                        sel_lane  = 1'b0;
                        rr_next   = 1'b1;
                    end else if (not_empty[1]) begin
                        sel_valid = 1'b1;
                        sel_lane  = 1'b1;
                        rr_next   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        pop = sel_valid ? (sel_lane ? 2'b10 : 2'b01) : 2'b00;
    end

    // FIFO storage writes. The storage needs no reset because occupancy gates
    // all reads.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < 2; k++) begin
            if (push[k]) begin
                mem[k][wr_ptr[k]] <= lane_data[k];
            end
        end
    end

    // FIFO pointers and occupancy. The power-of-two depth makes pointer
    // wrapping free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < 2; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                occ[k]    <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                if (push[k]) wr_ptr[k] <= wr_ptr[k] + PTR_ONE;
                if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PTR_ONE;
                case ({push[k], pop[k]})
                    2'b10:   occ[k] <= occ[k] + OCC_ONE;
                    2'b01:   occ[k] <= occ[k] - OCC_ONE;
                    default: occ[k] <= occ[k];
                endcase
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid    <= 1'b0;
            o_data_bus <= '0;
            o_src      <= 1'b0;
            rr         <= 1'b0;
        end else begin
            rr <= rr_next;
            if (load) begin
                if (sel_valid) begin
                    o_data_bus <= mem[sel_lane][rd_ptr[sel_lane]];
                    o_src      <= sel_lane;
                    o_valid    <= 1'b1;
                end else begin
                    o_valid    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_combine_2x1_seq.sv
// Testbench for combine_2x1_seq.
// A scoreboard queue holds the expected {src, data} words. The monitor
// compares each output word when the downstream side accepts it.
module tb_combine_2x1_seq;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      i_valid;
    logic [2*DW-1:0] i_data_bus;
    logic [1:0]      o_ready;
    logic            o_valid;
    logic [DW-1:0]   o_data_bus;
    logic            o_src;
    logic            i_ready;
    logic            i_en;
    logic [1:0]      i_cmd;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW:0] exp_q [$];

    combine_2x1_seq #(.DATA_WIDTH(DW), .COMMMAND_WIDTH(2), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
        .o_src      (o_src),
        .i_ready    (i_ready),
        .i_en       (i_en),
        .i_cmd      (i_cmd)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic src, input logic [DW-1:0] data);
        exp_q.push_back({src, data});
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: a word that is valid with i_ready=1 and i_en=1 is consumed at the
    // next edge.
    always @(negedge clk) begin
        if (rst && i_en && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_word", 64'({o_src, o_data_bus}), 64'h1_DEAD_BEEF);
            end else begin
                check_eq("out_word", 64'({o_src, o_data_bus}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; i_valid = '0; i_data_bus = '0; i_ready = 1'b0; i_en = 1'b1; i_cmd = 2'b00;
        tick();
        check_eq("rst_o_valid", 64'(o_valid), 64'd0);
        check_eq("rst_o_data",  64'(o_data_bus), 64'd0);
        check_eq("rst_o_src",   64'(o_src), 64'd0);
        check_eq("rst_o_ready", 64'(o_ready), 64'd0);
        tick();
        rst = 1'b1;
        #1;
        check_eq("post_rst_ready", 64'(o_ready), 64'd3);

        // Low lane, single word
        i_cmd = 2'b01; i_ready = 1'b1;
        i_valid = 2'b01; i_data_bus = {32'h0, 32'hAAAA_AAAA};
        expect_word(1'b0, 32'hAAAA_AAAA);
        tick();
        i_valid = 2'b00;
        tick();
        check_eq("lat_o_valid", 64'(o_valid), 64'd1);
        check_eq("lat_o_data",  64'(o_data_bus), 64'hAAAA_AAAA);
        check_eq("lat_o_src",   64'(o_src), 64'd0);
        drain();

        // Merge: prefill both lanes, then round-robin
        i_cmd = 2'b00; i_ready = 1'b0;
        i_valid = 2'b11; i_data_bus = {32'hB000_0000, 32'hA000_0000};
        tick();
        i_data_bus = {32'hB000_0001, 32'hA000_0001};
        tick();
        i_valid = 2'b00;
        check_eq("full_ready", 64'(o_ready), 64'd0);
        expect_word(1'b0, 32'hA000_0000);
        expect_word(1'b1, 32'hB000_0000);
        expect_word(1'b0, 32'hA000_0001);
        expect_word(1'b1, 32'hB000_0001);
        i_cmd = 2'b11; i_ready = 1'b1;
        drain();

        // Backpressure on lane 0
        i_cmd = 2'b01; i_ready = 1'b0;
        i_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            i_data_bus = {32'h0, 32'hC000_0000 + 32'(i)};
            tick();
        end
        i_valid = 2'b00;
        check_eq("bp_ready", 64'(o_ready), 64'd2);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("bp_hold_valid", 64'(o_valid), 64'd1);
            check_eq("bp_hold_data",  64'(o_data_bus), 64'hC000_0000);
        end
        for (int i = 0; i < 3; i++) expect_word(1'b0, 32'hC000_0000 + 32'(i));
        i_ready = 1'b1;
        drain();

        // Enable freeze during a merge
        i_cmd = 2'b00; i_ready = 1'b0;
        i_valid = 2'b11; i_data_bus = {32'hD100_0000, 32'hD000_0000};
        tick();
        i_data_bus = {32'hD100_0001, 32'hD000_0001};
        tick();
        i_valid = 2'b00;
        expect_word(1'b0, 32'hD000_0000);
        expect_word(1'b1, 32'hD100_0000);
        expect_word(1'b0, 32'hD000_0001);
        expect_word(1'b1, 32'hD100_0001);
        i_cmd = 2'b11; i_ready = 1'b1;
        tick();
        i_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("en_ready", 64'(o_ready), 64'd0);
            check_eq("en_valid", 64'(o_valid), 64'd1);
            check_eq("en_data",  64'(o_data_bus), 64'hD000_0000);
        end
        i_en = 1'b1;
        drain();

        // Deselected lane keeps its word
        i_cmd = 2'b10; i_ready = 1'b1;
        i_valid = 2'b01; i_data_bus = {32'h0, 32'hBBBB_BBBB};
        tick();
        i_valid = 2'b00;
        repeat (3) tick();
        check_eq("desel_valid", 64'(o_valid), 64'd0);
        expect_word(1'b0, 32'hBBBB_BBBB);
        i_cmd = 2'b01;
        drain();

        // Streaming on the high lane, one word per cycle
        i_cmd = 2'b10; i_ready = 1'b1;
        i_valid = 2'b10;
        for (int i = 0; i < 4; i++) begin
            i_data_bus = {32'hE000_0000 + 32'(i), 32'h0};
            expect_word(1'b1, 32'hE000_0000 + 32'(i));
            tick();
            check_eq("stream_ready", 64'(o_ready[1]), 64'd1);
        end
        i_valid = 2'b00;
        drain();

        // Reset mid-stream discards buffered words
        i_cmd = 2'b00; i_ready = 1'b0;
        i_valid = 2'b11; i_data_bus = {32'hF100_0000, 32'hF000_0000};
        tick();
        i_data_bus = {32'hF100_0001, 32'hF000_0001};
        tick();
        i_valid = 2'b00;
        i_cmd = 2'b01;
        tick();
        check_eq("prerst_valid", 64'(o_valid), 64'd1);
        rst = 1'b0;
        #1;
        check_eq("midrst_valid", 64'(o_valid), 64'd0);
        check_eq("midrst_ready", 64'(o_ready), 64'd0);
        check_eq("midrst_data",  64'(o_data_bus), 64'd0);
        tick();
        rst = 1'b1; i_cmd = 2'b11; i_ready = 1'b1;
        #1;
        check_eq("relrst_ready", 64'(o_ready), 64'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("relrst_valid", 64'(o_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
